// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-macro signals around the unified-memory arbiter.
// The arbiter uses the slave view; the surrounding pipeline/memory uses the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              IfReq;
    logic [ADDR_W-1:0] IfAddr;
    logic              IfFlush;
    logic [31:0]       IfRData;
    logic              IfDone;
    logic              IfStall;

    logic              DReq;
    logic              DWrite;
    logic              DByte;
    logic [ADDR_W-1:0] DAddr;
    logic [31:0]       DWData;
    logic [31:0]       DRData;
    logic              DDone;
    logic              DStall;

    logic              MReq;
    logic              MWrite;
    logic [3:0]        MByteEn;
    logic [ADDR_W-1:0] MAddr;
    logic [31:0]       MWData;
    logic              MReady;
    logic              MRspValid;
    logic [31:0]       MRData;

    logic              Busy;

    modport slave (
        input  IfReq, IfAddr, IfFlush, DReq, DWrite, DByte, DAddr, DWData,
               MReady, MRspValid, MRData,
        output IfRData, IfDone, IfStall, DRData, DDone, DStall,
               MReq, MWrite, MByteEn, MAddr, MWData, Busy
    );

    modport master (
        output IfReq, IfAddr, IfFlush, DReq, DWrite, DByte, DAddr, DWData,
               MReady, MRspValid, MRData,
        input  IfRData, IfDone, IfStall, DRData, DDone, DStall,
               MReq, MWrite, MByteEn, MAddr, MWData, Busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data load/store,
// sequencing each access as request, accept, response, with fetch anti-starvation.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    localparam int             SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_D_STREAK);

    logic [1:0]        state_r;
    logic [1:0]        owner_r;
    logic [SW-1:0]     streak_r;
    logic              discard_r;
    logic              mreq_r;
    logic              mwrite_r;
    logic [3:0]        mbyteen_r;
    logic [ADDR_W-1:0] maddr_r;
    logic [31:0]       mwdata_r;
    logic [31:0]       if_rdata_r;
    logic              if_done_r;
    logic [31:0]       d_rdata_r;
    logic              d_done_r;

    logic              grant_d_s;
    logic              grant_if_s;
    logic              rsp_s;
    logic [ADDR_W-1:0] gnt_addr_s;
    logic              gnt_write_s;
    logic [3:0]        gnt_byteen_s;
    logic [31:0]       gnt_wdata_s;

    // Grant decision in IDLE: data wins unless the fetch has been starved for a full streak.
    always_comb begin
        grant_d_s  = 1'b0;
        grant_if_s = 1'b0;
        rsp_s      = (state_r == ST_WAIT) && bus.MRspValid;
        if (state_r == ST_IDLE) begin
            if (bus.DReq && !(bus.IfReq && (streak_r == STREAK_MAX))) begin
                grant_d_s = 1'b1;
            end else if (bus.IfReq && !bus.IfFlush) begin
                grant_if_s = 1'b1;
            end else begin
                grant_d_s  = 1'b0;
                grant_if_s = 1'b0;
            end
        end else begin
            grant_d_s  = 1'b0;
            grant_if_s = 1'b0;
        end
    end

    // Memory-side command for the winning requester; byte stores replicate the byte on all lanes.
    always_comb begin
        gnt_addr_s   = {bus.IfAddr[ADDR_W-1:2], 2'b00};
        gnt_write_s  = 1'b0;
        gnt_byteen_s = 4'hF;
        gnt_wdata_s  = 32'h0000_0000;
        if (grant_d_s) begin
            gnt_addr_s  = {bus.DAddr[ADDR_W-1:2], 2'b00};
            gnt_write_s = bus.DWrite;
            if (bus.DByte) begin
                gnt_byteen_s = 4'b0001 << bus.DAddr[1:0];
                gnt_wdata_s  = {4{bus.DWData[7:0]}};
            end else begin
                gnt_byteen_s = 4'hF;
                gnt_wdata_s  = bus.DWData;
            end
        end else begin
            gnt_addr_s  = {bus.IfAddr[ADDR_W-1:2], 2'b00};
            gnt_write_s = 1'b0;
        end
    end

    // Access sequencer: IDLE -> REQ (until accepted) -> WAIT (until response) -> IDLE.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r   <= ST_IDLE;
            owner_r   <= OWN_NONE;
            mreq_r    <= 1'b0;
            mwrite_r  <= 1'b0;
            mbyteen_r <= 4'h0;
            maddr_r   <= '0;
            mwdata_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_d_s || grant_if_s) begin
                        state_r   <= ST_REQ;
                        owner_r   <= grant_d_s ? OWN_D : OWN_IF;
                        mreq_r    <= 1'b1;
                        mwrite_r  <= gnt_write_s;
                        mbyteen_r <= gnt_byteen_s;
                        maddr_r   <= gnt_addr_s;
                        mwdata_r  <= gnt_wdata_s;
                    end
                end
                ST_REQ: begin
                    if (bus.MReady) begin
                        state_r <= ST_WAIT;
                        mreq_r  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (bus.MRspValid) begin
                        state_r <= ST_IDLE;
                        owner_r <= OWN_NONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    owner_r <= OWN_NONE;
                    mreq_r  <= 1'b0;
                end
            endcase
        end
    end

    // Consecutive data grants while a fetch waits; reaching the limit forces the next grant to fetch.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            streak_r <= '0;
        end else if (grant_d_s && bus.IfReq) begin
            streak_r <= (streak_r == STREAK_MAX) ? streak_r : streak_r + SW'(1);
        end else if (grant_if_s || ((state_r == ST_IDLE) && !bus.IfReq)) begin
            streak_r <= '0;
        end
    end

    // A flushed fetch still completes on the memory side but its result is dropped.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            discard_r <= 1'b0;
        end else if (rsp_s) begin
            discard_r <= 1'b0;
        end else if ((state_r != ST_IDLE) && (owner_r == OWN_IF) && bus.IfFlush) begin
            discard_r <= 1'b1;
        end
    end

    // Completion pulses and read-data capture, one cycle after the response.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            if_done_r  <= 1'b0;
            d_done_r   <= 1'b0;
            if_rdata_r <= 32'h0000_0000;
            d_rdata_r  <= 32'h0000_0000;
        end else begin
            if_done_r <= 1'b0;
            d_done_r  <= 1'b0;
            if (rsp_s && (owner_r == OWN_IF) && !(discard_r || bus.IfFlush)) begin
                if_done_r  <= 1'b1;
                if_rdata_r <= bus.MRData;
            end
            if (rsp_s && (owner_r == OWN_D)) begin
                d_done_r <= 1'b1;
                if (!mwrite_r) begin
                    d_rdata_r <= bus.MRData;
                end
            end
        end
    end

    assign bus.MReq    = mreq_r;
    assign bus.MWrite  = mwrite_r;
    assign bus.MByteEn = mbyteen_r;
    assign bus.MAddr   = maddr_r;
    assign bus.MWData  = mwdata_r;
    assign bus.IfRData = if_rdata_r;
    assign bus.IfDone  = if_done_r;
    assign bus.DRData  = d_rdata_r;
    assign bus.DDone   = d_done_r;
    assign bus.IfStall = bus.IfReq & ~if_done_r;
    assign bus.DStall  = bus.DReq & ~d_done_r;
    assign bus.Busy    = (state_r != ST_IDLE);
endmodule
